// File: rtl/aes_shift_rows_pipe_if.sv
// Stream bundle for the ShiftRows pipe: input beat channel, output beat channel
// and the completed-transfer counter.
interface aes_shift_rows_pipe_if #(
    parameter int NB    = 4,
    parameter int TAG_W = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_inv;
    logic [TAG_W-1:0]     in_tag;
    logic [32*NB-1:0]     in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [32*NB-1:0]     out_data;
    logic [TAG_W-1:0]     out_tag;
    logic [15:0]          blk_cnt;

    modport slave (
        input  in_valid,
        input  in_inv,
        input  in_tag,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_tag,
        output blk_cnt
    );

    modport master (
        output in_valid,
        output in_inv,
        output in_tag,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_tag,
        input  blk_cnt
    );
endinterface

// File: rtl/aes_shift_rows_pipe.sv
// AES / Rijndael ShiftRows (forward or inverse, chosen per beat) followed by a
// 1- or 2-deep valid/ready register pipeline with a tag sideband.
module aes_shift_rows_pipe #(
    parameter int NB     = 4,
    parameter int STAGES = 1,
    parameter int TAG_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    aes_shift_rows_pipe_if.slave  bus
);
    localparam int W = 32 * NB;

    generate
        if (NB != 4 && NB != 6 && NB != 8) begin : g_bad_nb
            $error("aes_shift_rows_pipe: NB must be 4, 6 or 8");
        end
        if (STAGES != 1 && STAGES != 2) begin : g_bad_stages
            $error("aes_shift_rows_pipe: STAGES must be 1 or 2");
        end
        if (TAG_W < 1) begin : g_bad_tag
            $error("aes_shift_rows_pipe: TAG_W must be at least 1");
        end
    endgenerate

    // Rijndael with 256-bit blocks skips a row offset: rows shift by 0,1,3,4.
    function automatic int row_shift(input int r);
        if (NB == 8 && r >= 2) return r + 1;
        return r;
    endfunction

    logic [W-1:0] perm_fwd;
    logic [W-1:0] perm_inv;
    logic [W-1:0] perm;

    for (genvar c = 0; c < NB; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            localparam int SH    = row_shift(r);
            localparam int SRC_F = (c + SH) % NB;
            localparam int SRC_I = (c + NB - SH) % NB;
            assign perm_fwd[32*c+31-8*r -: 8] = bus.in_data[32*SRC_F+31-8*r -: 8];
            assign perm_inv[32*c+31-8*r -: 8] = bus.in_data[32*SRC_I+31-8*r -: 8];
        end
    end

    assign perm = bus.in_inv ? perm_inv : perm_fwd;

    logic             s1_valid;
    logic [W-1:0]     s1_data;
    logic [TAG_W-1:0] s1_tag;
    logic             s1_ready;
    logic             down_ready;

    logic             out_valid;
    logic [W-1:0]     out_data;
    logic [TAG_W-1:0] out_tag;
    logic [15:0]      blk_cnt_q;

    // in_ready is a pure function of pipeline state and out_ready, never in_valid.
    assign s1_ready     = !s1_valid || down_ready;
    assign bus.in_ready = s1_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_tag   <= '0;
        end else if (s1_ready) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_data <= perm;
                s1_tag  <= bus.in_tag;
            end
        end
    end

    generate
        if (STAGES == 2) begin : g_two
            logic             s2_valid;
            logic [W-1:0]     s2_data;
            logic [TAG_W-1:0] s2_tag;

            assign down_ready = !s2_valid || bus.out_ready;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s2_valid <= 1'b0;
                    s2_data  <= '0;
                    s2_tag   <= '0;
                end else if (down_ready) begin
                    s2_valid <= s1_valid;
                    if (s1_valid) begin
                        s2_data <= s1_data;
                        s2_tag  <= s1_tag;
                    end
                end
            end

            assign out_valid = s2_valid;
            assign out_data  = s2_data;
            assign out_tag   = s2_tag;
        end else begin : g_one
            assign down_ready = bus.out_ready;
            assign out_valid  = s1_valid;
            assign out_data   = s1_data;
            assign out_tag    = s1_tag;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_cnt_q <= 16'h0000;
        end else if (out_valid && bus.out_ready) begin
            blk_cnt_q <= blk_cnt_q + 16'h0001;
        end
    end

    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data;
    assign bus.out_tag   = out_tag;
    assign bus.blk_cnt   = blk_cnt_q;
endmodule

// File: tb/tb_aes_shift_rows_pipe.sv
// Scoreboard bench for aes_shift_rows_pipe: an NB=4/1-stage and an NB=8/2-stage
// instance share clock and reset.
module tb_aes_shift_rows_pipe;
    localparam int TAG_W = 4;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [255:0]     data;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n;
    logic rnd_on = 1'b0;

    always #5 clk = ~clk;

    aes_shift_rows_pipe_if #(.NB(4), .TAG_W(TAG_W)) ia ();
    aes_shift_rows_pipe_if #(.NB(8), .TAG_W(TAG_W)) ib ();

    aes_shift_rows_pipe #(.NB(4), .STAGES(1), .TAG_W(TAG_W)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ia));
    aes_shift_rows_pipe #(.NB(8), .STAGES(2), .TAG_W(TAG_W)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ib));

    beat_t       q_a[$];
    beat_t       q_b[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] cnt_a = 16'h0;
    logic [15:0] cnt_b = 16'h0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] ref_shift(input logic [255:0] d, input int nb, input bit inv);
        int           sh[4];
        int           src;
        logic [255:0] res;
        res = '0;
        if (nb == 8) begin
            sh[0] = 0; sh[1] = 1; sh[2] = 3; sh[3] = 4;
        end else begin
            sh[0] = 0; sh[1] = 1; sh[2] = 2; sh[3] = 3;
        end
        for (int c = 0; c < nb; c++) begin
            for (int r = 0; r < 4; r++) begin
                src = inv ? (c + nb - sh[r]) % nb : (c + sh[r]) % nb;
                res[32*c+31-8*r -: 8] = d[32*src+31-8*r -: 8];
            end
        end
        return res;
    endfunction

    function automatic logic [255:0] idx_pattern(input int nb);
        logic [255:0] p;
        p = '0;
        for (int c = 0; c < nb; c++)
            for (int r = 0; r < 4; r++)
                p[32*c+31-8*r -: 8] = 8'(4*c + r);
        return p;
    endfunction

    function automatic logic [255:0] rand_data();
        logic [255:0] d;
        for (int w = 0; w < 8; w++) d[32*w +: 32] = $urandom;
        return d;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        q_a.delete();
        q_b.delete();
        cnt_a = 16'h0;
        cnt_b = 16'h0;
    endtask

    // Scoreboard monitors: sample mid-cycle, handshakes complete on the next rising edge.
    initial begin : mon_a
        logic             hold;
        logic [255:0]     hold_data;
        logic [TAG_W-1:0] hold_tag;
        beat_t            b;
        hold = 1'b0;
        hold_data = '0;
        hold_tag = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    chk("hold_valid_a", 256'(ia.out_valid), 256'd1);
                    chk("hold_data_a", 256'(ia.out_data), hold_data);
                    chk("hold_tag_a", 256'(ia.out_tag), 256'(hold_tag));
                end
                hold      = ia.out_valid && !ia.out_ready;
                hold_data = 256'(ia.out_data);
                hold_tag  = ia.out_tag;
                if (ia.in_valid && ia.in_ready) begin
                    b.tag  = ia.in_tag;
                    b.data = ref_shift(256'(ia.in_data), 4, ia.in_inv);
                    q_a.push_back(b);
                end
                if (ia.out_valid && ia.out_ready) begin
                    if (q_a.size() == 0) begin
                        chk("unexpected_beat_a", 256'(ia.out_valid), 256'd0);
                    end else begin
                        b = q_a.pop_front();
                        chk("data_a", 256'(ia.out_data), b.data);
                        chk("tag_a", 256'(ia.out_tag), 256'(b.tag));
                    end
                    chk("blk_cnt_a", 256'(ia.blk_cnt), 256'(cnt_a));
                    cnt_a = cnt_a + 16'h1;
                end
            end
        end
    end

    initial begin : mon_b
        logic             hold;
        logic [255:0]     hold_data;
        logic [TAG_W-1:0] hold_tag;
        beat_t            b;
        hold = 1'b0;
        hold_data = '0;
        hold_tag = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    chk("hold_valid_b", 256'(ib.out_valid), 256'd1);
                    chk("hold_data_b", ib.out_data, hold_data);
                    chk("hold_tag_b", 256'(ib.out_tag), 256'(hold_tag));
                end
                hold      = ib.out_valid && !ib.out_ready;
                hold_data = ib.out_data;
                hold_tag  = ib.out_tag;
                if (ib.in_valid && ib.in_ready) begin
                    b.tag  = ib.in_tag;
                    b.data = ref_shift(ib.in_data, 8, ib.in_inv);
                    q_b.push_back(b);
                end
                if (ib.out_valid && ib.out_ready) begin
                    if (q_b.size() == 0) begin
                        chk("unexpected_beat_b", 256'(ib.out_valid), 256'd0);
                    end else begin
                        b = q_b.pop_front();
                        chk("data_b", ib.out_data, b.data);
                        chk("tag_b", 256'(ib.out_tag), 256'(b.tag));
                    end
                    chk("blk_cnt_b", 256'(ib.blk_cnt), 256'(cnt_b));
                    cnt_b = cnt_b + 16'h1;
                end
            end
        end
    end

    initial begin : rnd_ready
        forever begin
            @(posedge clk);
            #1;
            if (rnd_on) begin
                ia.out_ready = ($urandom_range(0, 3) != 0);
                ib.out_ready = ($urandom_range(0, 2) != 0);
            end
        end
    end

    task automatic drive_a(input int n);
        logic [255:0] d;
        bit           acc;
        int           waitc;
        for (int i = 0; i < n; i++) begin
            ia.in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) step();
            d = rand_data();
            ia.in_valid = 1'b1;
            ia.in_inv   = 1'($urandom_range(0, 1));
            ia.in_tag   = TAG_W'($urandom);
            ia.in_data  = d[127:0];
            acc = 1'b0;
            waitc = 0;
            while (!acc && waitc < 200) begin
                @(negedge clk);
                acc = ia.in_ready;
                step();
                waitc++;
            end
            if (!acc) chk("accept_timeout_a", 256'(acc), 256'd1);
        end
        ia.in_valid = 1'b0;
    endtask

    task automatic drive_b(input int n);
        bit acc;
        int waitc;
        for (int i = 0; i < n; i++) begin
            ib.in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) step();
            ib.in_valid = 1'b1;
            ib.in_inv   = 1'($urandom_range(0, 1));
            ib.in_tag   = TAG_W'($urandom);
            ib.in_data  = rand_data();
            acc = 1'b0;
            waitc = 0;
            while (!acc && waitc < 200) begin
                @(negedge clk);
                acc = ib.in_ready;
                step();
                waitc++;
            end
            if (!acc) chk("accept_timeout_b", 256'(acc), 256'd1);
        end
        ib.in_valid = 1'b0;
    endtask

    task automatic do_reset();
        ia.in_valid = 1'b0;
        ib.in_valid = 1'b0;
        rst_n = 1'b0;
        flush();
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin : main
        logic [255:0] d;
        logic [255:0] tmp;
        int           acc;
        int           k;

        ia.in_valid = 1'b0; ia.in_inv = 1'b0; ia.in_tag = '0; ia.in_data = '0; ia.out_ready = 1'b0;
        ib.in_valid = 1'b0; ib.in_inv = 1'b0; ib.in_tag = '0; ib.in_data = '0; ib.out_ready = 1'b0;
        rst_n = 1'b0;
        step();
        step();
        chk("rst_out_valid_a", 256'(ia.out_valid), 256'd0);
        chk("rst_out_valid_b", 256'(ib.out_valid), 256'd0);
        chk("rst_blk_cnt_a", 256'(ia.blk_cnt), 256'd0);
        chk("rst_out_data_a", 256'(ia.out_data), 256'd0);
        chk("rst_out_tag_b", 256'(ib.out_tag), 256'd0);
        rst_n = 1'b1;
        chk("in_ready_after_rst_a", 256'(ia.in_ready), 256'd1);
        chk("in_ready_after_rst_b", 256'(ib.in_ready), 256'd1);

        // Directed index patterns: forward on both, then inverse on the NB=4 instance.
        ia.out_ready = 1'b1;
        ib.out_ready = 1'b1;
        d = idx_pattern(4);
        ia.in_data = d[127:0]; ia.in_inv = 1'b0; ia.in_tag = 4'h5; ia.in_valid = 1'b1;
        ib.in_data = idx_pattern(8); ib.in_inv = 1'b0; ib.in_tag = 4'h6; ib.in_valid = 1'b1;
        step();
        chk("lat1_valid_a", 256'(ia.out_valid), 256'd1);
        chk("fwd_col0_nb4", 256'(ia.out_data[31:0]), 256'h00050A0F);
        chk("lat2_notyet_b", 256'(ib.out_valid), 256'd0);
        ib.in_valid = 1'b0;
        ia.in_inv = 1'b1; ia.in_tag = 4'h7;
        step();
        ia.in_valid = 1'b0;
        chk("inv_col0_nb4", 256'(ia.out_data[31:0]), 256'h000D0A07);
        chk("lat2_valid_b", 256'(ib.out_valid), 256'd1);
        chk("fwd_col0_nb8", 256'(ib.out_data[31:0]), 256'h00050E13);
        step();
        step();

        // Forward then inverse round trip on random data.
        d = rand_data();
        ia.in_data = d[127:0]; ia.in_inv = 1'b0; ia.in_valid = 1'b1;
        step();
        ia.in_valid = 1'b0;
        tmp = 256'(ia.out_data);
        ia.in_data = tmp[127:0]; ia.in_inv = 1'b1; ia.in_valid = 1'b1;
        step();
        ia.in_valid = 1'b0;
        chk("roundtrip_a", 256'(ia.out_data), 256'(d[127:0]));
        step();

        // Random traffic with random backpressure on both instances.
        rnd_on = 1'b1;
        fork
            drive_a(300);
            drive_b(300);
        join
        rnd_on = 1'b0;
        step();
        ia.out_ready = 1'b1;
        ib.out_ready = 1'b1;
        k = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && k < 50) begin
            step();
            k++;
        end
        chk("drain_a", 256'(q_a.size()), 256'd0);
        chk("drain_b", 256'(q_b.size()), 256'd0);

        // Two-stage fill under backpressure, then release.
        ib.out_ready = 1'b0;
        ib.in_inv = 1'b0; ib.in_tag = 4'h1; ib.in_data = rand_data(); ib.in_valid = 1'b1;
        acc = 0;
        repeat (6) begin
            @(negedge clk);
            if (ib.in_ready) begin
                acc++;
                step();
                ib.in_tag = TAG_W'(acc + 1);
                ib.in_inv = ~ib.in_inv;
                ib.in_data = rand_data();
            end else begin
                step();
            end
        end
        chk("accepted_while_blocked_b", 256'(acc), 256'd2);
        chk("in_ready_full_b", 256'(ib.in_ready), 256'd0);
        ib.out_ready = 1'b1;
        for (int t = 1; t <= 3; t++) begin
            @(negedge clk);
            if (t == 1) chk("in_ready_full_drain_b", 256'(ib.in_ready), 256'd1);
            chk("release_valid_b", 256'(ib.out_valid), 256'd1);
            chk("release_tag_b", 256'(ib.out_tag), 256'(t));
            step();
            if (t == 1) ib.in_valid = 1'b0;
        end
        step();

        // Mid-stream reset with a held beat and blk_cnt at 5.
        do_reset();
        ia.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            d = rand_data();
            ia.in_data = d[127:0]; ia.in_tag = TAG_W'(i); ia.in_valid = 1'b1;
            step();
        end
        ia.in_valid = 1'b0;
        step();
        ia.out_ready = 1'b0;
        ia.in_valid = 1'b1;
        ib.in_valid = 1'b1; ib.out_ready = 1'b0;
        step();
        ia.in_valid = 1'b0;
        ib.in_valid = 1'b0;
        chk("pre_rst_blk_cnt_a", 256'(ia.blk_cnt), 256'd5);
        chk("pre_rst_valid_a", 256'(ia.out_valid), 256'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid_a", 256'(ia.out_valid), 256'd0);
        chk("async_rst_blk_cnt_a", 256'(ia.blk_cnt), 256'd0);
        chk("async_rst_data_a", 256'(ia.out_data), 256'd0);
        chk("async_rst_tag_a", 256'(ia.out_tag), 256'd0);
        chk("async_rst_valid_b", 256'(ib.out_valid), 256'd0);
        flush();
        step();
        rst_n = 1'b1;
        ia.out_ready = 1'b1;
        ib.out_ready = 1'b1;
        repeat (4) begin
            step();
            chk("stale_valid_a", 256'(ia.out_valid), 256'd0);
            chk("stale_valid_b", 256'(ib.out_valid), 256'd0);
        end

        // 65537 back-to-back transfers wrap blk_cnt to 1.
        do_reset();
        ia.out_ready = 1'b1;
        ia.in_valid = 1'b1;
        for (int i = 0; i < 65537; i++) begin
            ia.in_inv  = 1'(i);
            ia.in_tag  = TAG_W'(i);
            ia.in_data = {4{32'(i)}};
            step();
        end
        ia.in_valid = 1'b0;
        step();
        step();
        chk("blk_cnt_wrap_a", 256'(ia.blk_cnt), 256'h0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d mismatched %0d", n_cmp, n_err);
        $fatal(1, "watchdog expired");
    end
endmodule
